// File: rtl/edge_detect_multi.sv
// edge_detect_multi
//   Multi-channel debounced edge detector. Each channel filters its input
//   level through an INIT/LOW/HIGH state machine and, on a qualified edge,
//   emits a registered one-cycle pulse, sets a sticky flag and bumps a
//   saturating event counter.
//
// Ports
//   clock         : rising-edge clock
//   reset         : asynchronous active-high reset, clears all state
//   inpt          : per-channel data input (already synchronous to clock)
//   mode          : per-channel edge select at [2i+1:2i]
//                   00 off, 01 rising, 10 falling, 11 both
//   clr           : per-channel clear of sticky and evt_count
//   outpt         : per-channel one-cycle event pulse
//   sticky        : per-channel flag, set by an event, held until clr
//   evt_count     : per-channel saturating count at [CNT_W*i +: CNT_W]
//   present_state : per-channel FSM state at [2i+1:2i]
module edge_detect_multi #(
    parameter int CHANNELS   = 4,
    parameter int FILTER_LEN = 3,
    parameter int CNT_W      = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       inpt,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS-1:0]       outpt,
    output logic [CHANNELS-1:0]       sticky,
    output logic [CHANNELS*CNT_W-1:0] evt_count,
    output logic [2*CHANNELS-1:0]     present_state
);

    localparam int            FW   = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLEN = FW'(FILTER_LEN);

    typedef enum logic [1:0] {
        ST_ILLEGAL = 2'b00,
        ST_INIT    = 2'b01,
        ST_LOW     = 2'b10,
        ST_HIGH    = 2'b11
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t          state_q, state_d;
        logic [FW-1:0]   fcnt_q, fcnt_d;
        logic            prev_q;
        logic            rise_p0, fall_p0, evt_p0;
        logic            pulse_p1, sticky_p1;
        logic [CNT_W-1:0] cnt_p1;

        // Stage p0: filter and edge decision from the current sample
        always_comb begin
            state_d = state_q;
            fcnt_d  = fcnt_q;
            rise_p0 = 1'b0;
            fall_p0 = 1'b0;
            case (state_q)
                ST_INIT: begin
                    // fcnt of zero means no sample has been seen since reset,
                    // so the first sample always starts a fresh run.
                    if (fcnt_q == '0 || inpt[i] != prev_q)
                        fcnt_d = FW'(1);
                    else
                        fcnt_d = fcnt_q + FW'(1);
                    if (fcnt_d == FLEN) begin
                        state_d = inpt[i] ? ST_HIGH : ST_LOW;
                        fcnt_d  = '0;
                    end
                end
                ST_LOW: begin
                    if (inpt[i]) begin
                        fcnt_d = fcnt_q + FW'(1);
                        if (fcnt_d == FLEN) begin
                            state_d = ST_HIGH;
                            fcnt_d  = '0;
                            rise_p0 = 1'b1;
                        end
                    end else begin
                        fcnt_d = '0;
                    end
                end
                ST_HIGH: begin
                    if (!inpt[i]) begin
                        fcnt_d = fcnt_q + FW'(1);
                        if (fcnt_d == FLEN) begin
                            state_d = ST_LOW;
                            fcnt_d  = '0;
                            fall_p0 = 1'b1;
                        end
                    end else begin
                        fcnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    fcnt_d  = '0;
                end
            endcase
            evt_p0 = (rise_p0 && mode[2*i]) || (fall_p0 && mode[2*i+1]);
        end

        // Stage p1: registered state, pulse, sticky flag and counter
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q   <= ST_INIT;
                fcnt_q    <= '0;
                prev_q    <= 1'b0;
                pulse_p1  <= 1'b0;
                sticky_p1 <= 1'b0;
                cnt_p1    <= '0;
            end else begin
                state_q  <= state_d;
                fcnt_q   <= fcnt_d;
                prev_q   <= inpt[i];
                pulse_p1 <= evt_p0;
                // An event coinciding with clr restarts the count at one.
                if (evt_p0) begin
                    sticky_p1 <= 1'b1;
                    cnt_p1    <= clr[i] ? CNT_W'(1) : sat_inc(cnt_p1);
                end else if (clr[i]) begin
                    sticky_p1 <= 1'b0;
                    cnt_p1    <= '0;
                end
            end
        end

        assign outpt[i]                     = pulse_p1;
        assign sticky[i]                    = sticky_p1;
        assign evt_count[CNT_W*i +: CNT_W]  = cnt_p1;
        assign present_state[2*i +: 2]      = state_q;
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

    localparam int CH = 4;
    localparam int FL = 3;

    logic        clock;
    logic        reset;
    logic [3:0]  inpt;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  outpt;
    logic [3:0]  sticky;
    logic [31:0] evt_count;
    logic [7:0]  present_state;

    logic        inpt_s;
    logic [1:0]  mode_s;
    logic        clr_s;
    logic        outpt_s;
    logic        sticky_s;
    logic [1:0]  evt_count_s;
    logic [1:0]  present_state_s;

    int checks   = 0;
    int failures = 0;

    // Reference model: level is known once the last FL samples agree.
    int run [CH];
    int lvl [CH];
    bit last [CH];
    bit have [CH];
    bit m_out [CH];
    bit m_sticky [CH];
    int m_cnt [CH];

    edge_detect_multi #(.CHANNELS(4), .FILTER_LEN(3), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .inpt(inpt), .mode(mode), .clr(clr),
        .outpt(outpt), .sticky(sticky), .evt_count(evt_count),
        .present_state(present_state)
    );

    edge_detect_multi #(.CHANNELS(1), .FILTER_LEN(1), .CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .inpt(inpt_s), .mode(mode_s), .clr(clr_s),
        .outpt(outpt_s), .sticky(sticky_s), .evt_count(evt_count_s),
        .present_state(present_state_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            run[i] = 0; lvl[i] = -1; last[i] = 0; have[i] = 0;
            m_out[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        bit s, rise, fall, ev;
        for (int i = 0; i < CH; i++) begin
            s = inpt[i];
            rise = 0; fall = 0;
            run[i] = (have[i] && s == last[i]) ? run[i] + 1 : 1;
            have[i] = 1; last[i] = s;
            if (run[i] >= FL && lvl[i] != int'(s)) begin
                if (lvl[i] == 0) rise = 1;
                if (lvl[i] == 1) fall = 1;
                lvl[i] = int'(s);
            end
            ev = (rise && mode[2*i]) || (fall && mode[2*i+1]);
            m_out[i] = ev;
            if (ev) begin
                m_sticky[i] = 1;
                m_cnt[i] = clr[i] ? 1 : ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255);
            end else if (clr[i]) begin
                m_sticky[i] = 0;
                m_cnt[i] = 0;
            end
        end
    endtask

    task automatic compare();
        logic [31:0] e_out, e_st, e_cnt, e_ps;
        e_out = '0; e_st = '0; e_cnt = '0; e_ps = '0;
        for (int i = 0; i < CH; i++) begin
            e_out[i] = m_out[i];
            e_st[i]  = m_sticky[i];
            e_cnt[8*i +: 8] = 8'(m_cnt[i]);
            e_ps[2*i +: 2] = (lvl[i] < 0) ? 2'b01 : ((lvl[i] == 0) ? 2'b10 : 2'b11);
        end
        check("model_outpt", {28'b0, outpt}, e_out);
        check("model_sticky", {28'b0, sticky}, e_st);
        check("model_evt_count", evt_count, e_cnt);
        check("model_state", {24'b0, present_state}, e_ps);
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset(); else model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset = 1'b1; inpt = 4'b0101; mode = 8'h00; clr = 4'h0;
        inpt_s = 1'b0; mode_s = 2'b11; clr_s = 1'b0;
        model_reset();

        // reset and INIT
        ticks(2);
        check("reset_state", {24'b0, present_state}, 32'h55);
        check("reset_outpt", {28'b0, outpt}, 32'h0);
        check("reset_count", evt_count, 32'h0);
        reset = 1'b0;
        ticks(2);
        check("init_hold_2", {24'b0, present_state}, 32'h55);
        tick();
        check("init_done", {24'b0, present_state}, 32'hBB);
        check("init_no_pulse", {28'b0, outpt}, 32'h0);
        check("init_count", evt_count, 32'h0);

        // filtering and latency on ch0
        inpt = 4'b0000; ticks(4);
        mode = 8'h01;
        inpt = 4'b0001; tick(); check("glitch_t1", {31'b0, outpt[0]}, 0);
        tick();                 check("glitch_t2", {31'b0, outpt[0]}, 0);
        inpt = 4'b0000; tick(); check("glitch_t3", {31'b0, outpt[0]}, 0);
        inpt = 4'b0001; tick(); check("stable_t1", {31'b0, outpt[0]}, 0);
        tick();                 check("stable_t2", {31'b0, outpt[0]}, 0);
        tick();                 check("stable_t3", {31'b0, outpt[0]}, 1);
        tick();                 check("stable_t4", {31'b0, outpt[0]}, 0);
        check("filter_count", {24'b0, evt_count[7:0]}, 1);

        // mode coverage
        mode = 8'h00; inpt = 4'b0000; ticks(4);
        clr = 4'hF; tick(); clr = 4'h0;
        check("cleared_count", evt_count, 32'h0);
        mode = 8'hE4;
        inpt = 4'b1111; ticks(4);
        inpt = 4'b0000; ticks(4);
        check("mode_counts", evt_count, 32'h02010100);
        check("mode_sticky", {28'b0, sticky}, 32'hE);

        // clear colliding with an event on ch1
        mode = 8'hEC;
        for (int r = 0; r < 2; r++) begin
            inpt = 4'b0010; ticks(4);
            inpt = 4'b0000; ticks(4);
        end
        check("pre_clr_counts", evt_count, 32'h02010500);
        inpt = 4'b0010; ticks(2);
        clr = 4'b0010; tick(); clr = 4'b0000;
        check("clr_evt_count", {24'b0, evt_count[15:8]}, 1);
        check("clr_evt_sticky", {31'b0, sticky[1]}, 1);
        check("clr_evt_pulse", {31'b0, outpt[1]}, 1);

        // asynchronous reset mid filter on ch2
        inpt = 4'b0110; ticks(2);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_outpt", {28'b0, outpt}, 32'h0);
        check("async_sticky", {28'b0, sticky}, 32'h0);
        check("async_count", evt_count, 32'h0);
        check("async_state", {24'b0, present_state}, 32'h55);
        tick();
        reset = 1'b0;
        ticks(2);
        check("post_reset_init", {24'b0, present_state}, 32'h55);
        tick();
        check("post_reset_state", {24'b0, present_state}, 32'hBE);
        check("post_reset_count", evt_count, 32'h0);
        inpt = 4'b0000; ticks(2);
        tick();
        check("post_reset_pulse", {28'b0, outpt}, 32'h6);
        check("post_reset_evt", evt_count, 32'h00010100);

        // saturation with FILTER_LEN=1, CNT_W=2
        for (int k = 1; k <= 6; k++) begin
            inpt_s = ~inpt_s;
            tick();
            check("sat_count", {30'b0, evt_count_s}, (k < 3) ? k : 3);
            check("sat_pulse", {31'b0, outpt_s}, 1);
        end

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 3) == 0) inpt[i] = ~inpt[i];
            if ($urandom_range(0, 31) == 0) mode = 8'($urandom);
            for (int i = 0; i < CH; i++)
                clr[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel successor to the team's single-bit transition-detector FSM. Each channel tracks a debounced input level with a three-state machine (INIT/LOW/HIGH) and emits a registered one-cycle pulse on a qualified edge. The edge is selected per channel as rising, falling, both or off. Each channel also keeps a sticky flag and a saturating event counter for a polling controller. Sits between raw synchronous status/strobe lines and the control logic that consumes edge events.

## Interface
- CHANNELS, 4: number of independent channels (1..32).
- FILTER_LEN, 3: consecutive identical samples required to accept a level change (1..255); 1 = no filtering.
- CNT_W, 8: width of each per-channel event counter (1..16).

- clock  in  1: single clock; all state updates on rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- inpt  in  CHANNELS: per-channel data inputs, synchronous to clock; no internal synchroniser.
- mode  in  2*CHANNELS: per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- clr  in  CHANNELS: per-channel synchronous clear of sticky and evt_count.
- outpt  out  CHANNELS: registered one-cycle event pulse per channel.
- sticky  out  CHANNELS: per-channel flag, set by any qualified event, held until clr.
- evt_count  out  CHANNELS*CNT_W: per-channel saturating event count, channel i at [CNT_W*i +: CNT_W].
- present_state  out  2*CHANNELS: per-channel FSM state, channel i at [2i+1:2i].

## Operation
- State encoding per channel: INIT=2'b01, LOW=2'b10, HIGH=2'b11. 2'b00 is illegal and goes to INIT on the next edge with no event.
- Per-channel filter counter fcnt, width $clog2(FILTER_LEN+1).
- INIT:
  - Counts consecutive equal samples of inpt[i]; fcnt restarts at 1 when the sample differs from the previous one.
  - On the FILTER_LEN-th equal sample, moves to LOW (sample 0) or HIGH (sample 1).
  - Never generates an event.
- LOW:
  - Each sample of 1 increments fcnt; any sample of 0 clears fcnt.
  - On the FILTER_LEN-th consecutive 1, moves to HIGH, clears fcnt and raises a rising edge.
- HIGH: mirror of LOW. FILTER_LEN consecutive 0 samples move to LOW and raise a falling edge.
- Qualified event = rising edge with mode 01 or 11, or falling edge with mode 10 or 11.
- Mode 00 still tracks level; it only suppresses events.
- On a qualified event:
  - outpt[i]=1 for the following cycle.
  - sticky[i] is set.
  - evt_count[i] increments, saturating at 2^CNT_W-1; no wrap.
- clr[i] clears sticky[i] and evt_count[i] at the next edge. If a qualified event occurs in the same cycle, the event wins: sticky[i]=1 and evt_count[i]=1. outpt is unaffected by clr.
- A mode change is sampled at the edge where the transition occurs; there is no retroactive event.
- Channels are fully independent; no shared arbitration.

## Timing
- Reset values: present_state = 2'b01 on every channel; outpt, sticky, evt_count, fcnt all 0.
- Reset asserted mid-operation clears everything asynchronously; any in-progress filter count is discarded.
- Pulse latency: a new level first sampled at edge k and held stable moves the state at edge k+FILTER_LEN-1. outpt is high from that edge until the next edge.
- FILTER_LEN=1 with inpt toggling every cycle in mode 11: outpt stays high continuously and evt_count increments every cycle.
- After reset release, a channel spends at least FILTER_LEN edges in INIT. The level present at release never produces an event.
- A glitch shorter than FILTER_LEN cycles produces no state change, pulse or count.

## Test plan
CHANNELS=4, FILTER_LEN=3, CNT_W=8 unless stated.
- Reset and INIT:
  - Stimulus: reset=1 for 2 cycles, release with inpt=4'b0101, hold.
  - Response: present_state=8'h55 during reset; after 3 edges, ch0/ch2=HIGH and ch1/ch3=LOW; outpt stays 0; evt_count all 0.
- Filtering and latency:
  - Stimulus: ch0 LOW, mode=01; inpt[0] high for 2 cycles, low, then high for 3 cycles.
  - Response: no event on the 2-cycle glitch; outpt[0] pulses exactly once, at the 3rd edge of the stable high; evt_count[0]=1.
- Mode coverage:
  - Stimulus: modes ch0..3 = 00/01/10/11; drive a full 0->1->0 cycle on all channels, each level held 4 cycles.
  - Response: evt_count = 0/1/1/2; sticky = 4'b1110.
- Saturation:
  - Stimulus: CNT_W=2, FILTER_LEN=1, mode 11; toggle inpt[0] for 6 cycles.
  - Response: evt_count[0] reaches 3 and stays 3.
- Clear vs event:
  - Stimulus: assert clr[1] in the same cycle ch1 completes a qualified edge, with prior evt_count=5.
  - Response: evt_count[1]=1, sticky[1]=1, outpt[1] pulses.
- Mid-operation reset:
  - Stimulus: assert reset asynchronously between edges while ch2 fcnt=2.
  - Response: outputs clear immediately without waiting for an edge; state=INIT; no event after release until FILTER_LEN stable samples plus a real edge.
